// File: rtl/ahb_cfg_sequencer_if.sv
// AHB-Lite proc_* register port shared by the config sequencer (master) and the platform slave.
interface ahb_cfg_sequencer_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] proc_haddr;
  logic [1:0]        proc_htrans;
  logic              proc_hwrite;
  logic [1:0]        proc_hsize;
  logic [DATA_W-1:0] proc_hwdata;
  logic              proc_hready;
  logic [DATA_W-1:0] proc_hrdata;
  logic [1:0]        proc_hresp;

  modport master (
    output proc_haddr, proc_htrans, proc_hwrite, proc_hsize, proc_hwdata,
    input  proc_hready, proc_hrdata, proc_hresp
  );

  modport slave (
    input  proc_haddr, proc_htrans, proc_hwrite, proc_hsize, proc_hwdata,
    output proc_hready, proc_hrdata, proc_hresp
  );
endinterface

// File: rtl/ahb_cfg_sequencer.sv
// Scripted AHB-Lite master: walks a script ROM of write / read-compare / wait entries,
// issuing one non-pipelined single word transfer at a time on the proc_* port.
module ahb_cfg_sequencer #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned DLY_W = 16
) (
  input  logic                 clk_80m,
  input  logic                 por_rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [IDX_W-1:0]     err_idx,
  output logic [7:0]           mismatch_cnt,
  output logic [IDX_W-1:0]     rom_addr,
  input  logic [66+DLY_W-1:0]  rom_rdata,
  ahb_cfg_sequencer_if.master  proc
);

  localparam int unsigned ROM_W  = 66 + DLY_W;
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] OP_END   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WAIT  = 2'b11;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HSIZE_WORD    = 2'b10;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_DELAY  = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_DATA   = 4'd5;
  localparam logic [3:0] S_NEXT   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  logic [3:0]       state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [1:0]       op_q,      op_d;
  logic [DLY_W-1:0] cnt_q,     cnt_d;
  logic [BUS_W-1:0] addr_q,    addr_d;
  logic [BUS_W-1:0] data_q,    data_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             error_q,   error_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [CNT_W-1:0] mm_cnt_q,  mm_cnt_d;
  logic             mm_seen_q, mm_seen_d;
  logic [BUS_W-1:0] haddr_q,   haddr_d;
  logic [1:0]       htrans_q,  htrans_d;
  logic             hwrite_q,  hwrite_d;
  logic [BUS_W-1:0] hwdata_q,  hwdata_d;
  logic             expire;

  logic [1:0]       rom_op;
  logic [DLY_W-1:0] rom_dly;
  logic [BUS_W-1:0] rom_addr_f;
  logic [BUS_W-1:0] rom_data_f;

  assign rom_op     = rom_rdata[ROM_W-1 -: 2];
  assign rom_dly    = rom_rdata[64 +: DLY_W];
  assign rom_addr_f = rom_rdata[32 +: BUS_W];
  assign rom_data_f = rom_rdata[0 +: BUS_W];

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_idx_d = err_idx_q;
    mm_cnt_d  = mm_cnt_q;
    mm_seen_d = mm_seen_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    hwdata_d  = hwdata_q;
    expire    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_FETCH;
          idx_d     = '0;
          err_idx_d = '0;
          mm_cnt_d  = '0;
          mm_seen_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d   = rom_op;
        cnt_d  = rom_dly;
        addr_d = rom_addr_f;
        data_d = rom_data_f;
        if (rom_op == OP_END)        state_d = S_DONE;
        else if (rom_dly != '0)      state_d = S_DELAY;
        else                         expire  = 1'b1;
      end
      S_DELAY: begin
        if (cnt_q == DLY_W'(1)) expire = 1'b1;
        else                    cnt_d  = cnt_q - DLY_W'(1);
      end
      S_ADDR: begin
        if (proc.proc_hready) begin
          state_d = S_DATA;
          if (op_q == OP_WRITE) hwdata_d = data_q;
        end
      end
      S_DATA: begin
        if (proc.proc_hresp == HRESP_ERROR) begin
          state_d   = S_ERR;
          err_idx_d = idx_q;
        end else if (proc.proc_hready) begin
          state_d = S_NEXT;
          if ((op_q == OP_READ) && (proc.proc_hrdata != data_q)) begin
            if (mm_cnt_q != '1) mm_cnt_d = mm_cnt_q + CNT_W'(1);
            if (!mm_seen_q) begin
              mm_seen_d = 1'b1;
              err_idx_d = idx_q;
            end
          end
        end
      end
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Delay expiry uses this entry's op/addr, whether just decoded or already latched
    if (expire) begin
      if (op_d == OP_WAIT) begin
        state_d = S_NEXT;
      end else begin
        state_d  = S_ADDR;
        haddr_d  = addr_d;
        hwrite_d = (op_d == OP_WRITE);
      end
    end

    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERR);
    htrans_d = (state_d == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  always_ff @(posedge clk_80m) begin
    if (!por_rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      op_q      <= OP_END;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      mm_cnt_q  <= '0;
      mm_seen_q <= 1'b0;
      haddr_q   <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      mm_cnt_q  <= mm_cnt_d;
      mm_seen_q <= mm_seen_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign err_idx           = err_idx_q;
  assign mismatch_cnt      = mm_cnt_q;
  assign rom_addr          = idx_q;
  assign proc.proc_haddr   = haddr_q;
  assign proc.proc_htrans  = htrans_q;
  assign proc.proc_hwrite  = hwrite_q;
  assign proc.proc_hsize   = HSIZE_WORD;
  assign proc.proc_hwdata  = hwdata_q;

endmodule

// File: tb/tb_ahb_cfg_sequencer.sv
// Bench for ahb_cfg_sequencer: script ROM + wait-state slave, checked against a
// cycle-cost model of the script computed directly from the entry rules.
module tb_ahb_cfg_sequencer;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned DLY_W = 16;
  localparam int unsigned ROM_W = 66 + DLY_W;
  localparam int N = 8;
  localparam logic [1:0] END = 2'b00, WR = 2'b01, RD = 2'b10, WT = 2'b11;

  logic clk_80m = 1'b0;
  logic por_rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, error;
  logic [IDX_W-1:0] err_idx, rom_addr;
  logic [7:0] mismatch_cnt;
  logic [ROM_W-1:0] rom_rdata;
  logic [ROM_W-1:0] rom [N];

  ahb_cfg_sequencer_if bus ();

  ahb_cfg_sequencer #(.IDX_W(IDX_W), .DLY_W(DLY_W)) dut (
    .clk_80m(clk_80m), .por_rst_n(por_rst_n), .start(start),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .mismatch_cnt(mismatch_cnt), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .proc(bus.master)
  );

  always #5 clk_80m = ~clk_80m;

  int cyc = 0;
  always @(posedge clk_80m) cyc <= cyc + 1;
  always @(posedge clk_80m) rom_rdata <= rom[rom_addr];

  int total = 0, bad = 0;

  // script and slave configuration (slave entries indexed by transfer number)
  logic [1:0]  s_op [N];
  int          s_dly [N];
  logic [31:0] s_addr [N], s_data [N];
  int          sl_aw [16], sl_dw [16];
  logic [31:0] sl_rdata [16];
  bit          sl_err [16];

  // expected results
  int e_term, e_first, e_nsc, e_last_idx, e_mm, e_err_idx;
  bit e_done, e_error;
  logic [31:0] e_addr [$], e_wdata [$];
  bit e_write [$];

  // observations
  int o_term, o_first, o_first_raw, o_nsc, o_unstable;
  logic o_busy0;
  logic [31:0] q_addr [$], q_wdata [$];
  bit q_write [$];

  // slave state
  int sl_k = 0, sl_phase = 0, sl_wait = 0;
  logic [31:0] ph_addr, ph_wdata;
  logic ph_write;

  initial begin
    bus.proc_hready = 1'b1;
    bus.proc_hresp  = 2'b00;
    bus.proc_hrdata = '0;
  end

  // Wait-state slave: drives hready/hrdata/hresp at negedge and records each transfer
  always @(negedge clk_80m) begin
    int k;
    k = sl_k % 16;
    if (!por_rst_n) begin
      bus.proc_hready = 1'b1; bus.proc_hresp = 2'b00; sl_phase = 0;
    end else if (sl_phase >= 2) begin
      if (bus.proc_htrans !== 2'b00 || bus.proc_haddr !== ph_addr || bus.proc_hwrite !== ph_write)
        o_unstable++;
      if (sl_phase == 2) begin
        ph_wdata = bus.proc_hwdata; sl_phase = 3; sl_wait = 0;
      end else if (ph_write && bus.proc_hwdata !== ph_wdata) begin
        o_unstable++;
      end
      if (sl_err[k] || sl_wait >= sl_dw[k]) begin
        bus.proc_hready = 1'b1;
        bus.proc_hresp  = sl_err[k] ? 2'b01 : 2'b00;
        bus.proc_hrdata = sl_rdata[k];
        q_addr.push_back(ph_addr); q_write.push_back(ph_write); q_wdata.push_back(ph_wdata);
        sl_k++; sl_phase = 0;
      end else begin
        bus.proc_hready = 1'b0; bus.proc_hrdata = $urandom; sl_wait++;
      end
    end else if (bus.proc_htrans === 2'b10) begin
      o_nsc++;
      if (o_first_raw < 0) o_first_raw = cyc;
      if (sl_phase == 0) begin
        ph_addr = bus.proc_haddr; ph_write = bus.proc_hwrite; sl_wait = 0; sl_phase = 1;
      end else if (bus.proc_haddr !== ph_addr || bus.proc_hwrite !== ph_write) begin
        o_unstable++;
      end
      if (sl_wait < sl_aw[k]) begin bus.proc_hready = 1'b0; sl_wait++; end
      else begin bus.proc_hready = 1'b1; sl_phase = 2; end
    end else begin
      if (sl_phase == 1) o_unstable++;
      sl_phase = 0; bus.proc_hready = 1'b1; bus.proc_hresp = 2'b00;
    end
  end

  task automatic clear_script();
    for (int i = 0; i < N; i++) begin
      s_op[i] = END; s_dly[i] = 0; s_addr[i] = '0; s_data[i] = '0; rom[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      sl_aw[i] = 0; sl_dw[i] = 0; sl_rdata[i] = '0; sl_err[i] = 0;
    end
  endtask

  task automatic set_entry(input int i, input logic [1:0] op, input int dly,
                           input logic [31:0] a, input logic [31:0] d);
    s_op[i] = op; s_dly[i] = dly; s_addr[i] = a; s_data[i] = d;
    rom[i] = {op, 16'(dly), a, d};
  endtask

  // Cost model: FETCH+DECODE = 2, delay = dly, address = 1+waits, data = 1+waits, NEXT = 1
  task automatic model();
    int t, k, idx;
    bit fin, mm_seen;
    e_addr.delete(); e_write.delete(); e_wdata.delete();
    t = 0; k = 0; idx = 0; fin = 0; mm_seen = 0;
    e_done = 0; e_error = 0; e_err_idx = 0; e_mm = 0; e_first = -1; e_nsc = 0;
    while (!fin) begin
      t += 2;
      if (s_op[idx] == END) begin
        e_done = 1; fin = 1;
      end else begin
        t += s_dly[idx];
        if (s_op[idx] == WT) begin
          t += 1;
        end else begin
          if (e_first < 0) e_first = t;
          e_nsc += 1 + sl_aw[k];
          t += 1 + sl_aw[k];
          e_addr.push_back(s_addr[idx]); e_write.push_back(s_op[idx] == WR);
          e_wdata.push_back(s_data[idx]);
          if (sl_err[k]) begin
            t += 1; e_error = 1; e_err_idx = idx; fin = 1;
          end else begin
            t += 1 + sl_dw[k];
            if (s_op[idx] == RD && sl_rdata[k] != s_data[idx]) begin
              if (e_mm < 255) e_mm++;
              if (!mm_seen) begin mm_seen = 1; e_err_idx = idx; end
            end
            t += 1;
          end
          k++;
        end
        if (!fin) begin
          if (idx == N - 1) begin e_done = 1; fin = 1; end
          else idx++;
        end
      end
    end
    e_term = t; e_last_idx = idx;
  endtask

  // Pulse start, then wait (bounded) for done or error; optional second start mid-run
  task automatic run_script(input int mid_start_at, input int budget);
    int s, n;
    @(posedge clk_80m); #1;
    sl_k = 0; q_addr.delete(); q_write.delete(); q_wdata.delete();
    o_nsc = 0; o_first_raw = -1; o_unstable = 0; o_term = -1; o_first = -1;
    @(negedge clk_80m); start = 1'b1;
    @(negedge clk_80m); start = 1'b0; s = cyc; o_busy0 = busy;
    n = 0;
    while (!(done || error) && n < budget) begin
      start = (n + 1 == mid_start_at);
      @(negedge clk_80m);
      n++;
    end
    start = 1'b0;
    if (done || error) o_term = cyc - s;
    if (o_first_raw >= 0) o_first = o_first_raw - s;
  endtask

  task automatic test_reset();
    por_rst_n = 1'b0;
    repeat (3) @(posedge clk_80m);
    @(negedge clk_80m);
    total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
    total++; if (bus.proc_htrans !== 2'b00) begin bad++; $display("FAIL reset_htrans: got %b want 00", bus.proc_htrans); end
    total++; if (bus.proc_hsize !== 2'b10) begin bad++; $display("FAIL reset_hsize: got %b want 10", bus.proc_hsize); end
    total++; if ({rom_addr, err_idx, mismatch_cnt} !== '0) begin bad++; $display("FAIL reset_idx: got %0h want 0", {rom_addr, err_idx, mismatch_cnt}); end
    total++; if ({bus.proc_haddr, bus.proc_hwdata, bus.proc_hwrite} !== '0) begin bad++; $display("FAIL reset_bus: got %0h want 0", {bus.proc_haddr, bus.proc_hwdata}); end
    por_rst_n = 1'b1;
    repeat (2) @(negedge clk_80m);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_write();
    clear_script();
    set_entry(0, WR, 0, 32'h6000_0000, 32'h2000_0001);
    model(); run_script(0, 200);
    total++; if (o_busy0 !== 1'b1) begin bad++; $display("FAIL sw_busy: got %b want 1", o_busy0); end
    total++; if (o_term != e_term) begin bad++; $display("FAIL sw_done_cycle: got %0d want %0d", o_term, e_term); end
    total++; if ({done, error, busy} !== 3'b100) begin bad++; $display("FAIL sw_flags: got %b want 100", {done, error, busy}); end
    total++; if (o_nsc != e_nsc) begin bad++; $display("FAIL sw_nonseq: got %0d want %0d", o_nsc, e_nsc); end
    total++; if (o_first != e_first) begin bad++; $display("FAIL sw_first_ns: got %0d want %0d", o_first, e_first); end
    total++; if (q_addr.size() != 1) begin bad++; $display("FAIL sw_ntxn: got %0d want 1", q_addr.size()); end
    else begin
      total++; if (q_addr[0] !== 32'h6000_0000 || q_write[0] !== 1'b1) begin bad++; $display("FAIL sw_addr: got %h/%b want 60000000/1", q_addr[0], q_write[0]); end
      total++; if (q_wdata[0] !== 32'h2000_0001) begin bad++; $display("FAIL sw_wdata: got %h want 20000001", q_wdata[0]); end
    end
  endtask

  task automatic test_delay();
    clear_script();
    set_entry(0, WR, 10, 32'h60B0_004C, 32'h0000_5FC1);
    model(); run_script(0, 200);
    total++; if (o_first != e_first) begin bad++; $display("FAIL dly_first_ns: got %0d want %0d", o_first, e_first); end
    total++; if (o_nsc != 1) begin bad++; $display("FAIL dly_nonseq: got %0d want 1", o_nsc); end
    total++; if (o_term != e_term) begin bad++; $display("FAIL dly_done_cycle: got %0d want %0d", o_term, e_term); end
    total++; if (q_wdata.size() != 1 || q_wdata[0] !== 32'h5FC1) begin bad++; $display("FAIL dly_wdata: got %0d txns want one of 5fc1", q_wdata.size()); end
  endtask

  task automatic test_wait_states();
    clear_script();
    set_entry(0, WR, 0, 32'h6000_0100, 32'hDEAD_BEEF);
    set_entry(1, WR, 0, 32'h6000_0104, 32'h0000_0001);
    sl_aw[0] = 3; sl_dw[0] = 2;
    model(); run_script(0, 200);
    total++; if (o_unstable != 0) begin bad++; $display("FAIL ws_stable: got %0d unstable cycles want 0", o_unstable); end
    total++; if (o_nsc != e_nsc) begin bad++; $display("FAIL ws_nonseq: got %0d want %0d", o_nsc, e_nsc); end
    total++; if (o_term != e_term) begin bad++; $display("FAIL ws_done_cycle: got %0d want %0d", o_term, e_term); end
    total++; if (q_addr.size() != 2) begin bad++; $display("FAIL ws_ntxn: got %0d want 2", q_addr.size()); end
    else begin
      total++; if (q_wdata[0] !== 32'hDEAD_BEEF || q_addr[1] !== 32'h6000_0104) begin bad++; $display("FAIL ws_txn: got %h/%h want deadbeef/60000104", q_wdata[0], q_addr[1]); end
    end
  endtask

  task automatic test_read_mismatch();
    clear_script();
    set_entry(0, WR, 0, 32'h6000_0010, 32'h0000_00A5);
    set_entry(1, RD, 0, 32'h60C0_0000, 32'h011E_AD8F); sl_rdata[1] = 32'h011E_AD8E;
    set_entry(2, RD, 2, 32'h60C0_0004, 32'h0000_1234); sl_rdata[2] = 32'h0000_1234;
    set_entry(3, WT, 4, 32'h0, 32'h0);
    set_entry(4, RD, 0, 32'h60C0_0008, 32'h0000_0055); sl_rdata[3] = 32'h0000_0054; sl_dw[3] = 1;
    set_entry(5, WR, 1, 32'h6000_0014, 32'h0000_0077);
    model(); run_script(0, 300);
    total++; if (mismatch_cnt !== 8'(e_mm)) begin bad++; $display("FAIL rd_mm_cnt: got %0d want %0d", mismatch_cnt, e_mm); end
    total++; if (err_idx !== IDX_W'(e_err_idx)) begin bad++; $display("FAIL rd_err_idx: got %0d want %0d", err_idx, e_err_idx); end
    total++; if ({done, error} !== 2'b10) begin bad++; $display("FAIL rd_flags: got %b want 10", {done, error}); end
    total++; if (q_addr.size() != e_addr.size()) begin bad++; $display("FAIL rd_ntxn: got %0d want %0d", q_addr.size(), e_addr.size()); end
    total++; if (o_term != e_term) begin bad++; $display("FAIL rd_done_cycle: got %0d want %0d", o_term, e_term); end
  endtask

  task automatic test_bus_error();
    clear_script();
    for (int i = 0; i < 5; i++) begin
      set_entry(i, (i % 2) ? RD : WR, i % 3, 32'h6100_0000 + 32'(4 * i), 32'h100 + 32'(i));
      sl_rdata[i] = 32'h100 + 32'(i);
    end
    sl_err[3] = 1;
    model(); run_script(0, 300);
    total++; if ({error, done, busy} !== 3'b100) begin bad++; $display("FAIL err_flags: got %b want 100", {error, done, busy}); end
    total++; if (err_idx !== IDX_W'(e_err_idx)) begin bad++; $display("FAIL err_idx: got %0d want %0d", err_idx, e_err_idx); end
    total++; if (o_term != e_term) begin bad++; $display("FAIL err_cycle: got %0d want %0d", o_term, e_term); end
    repeat (6) @(negedge clk_80m);
    total++; if (q_addr.size() != e_addr.size() || o_nsc != e_nsc) begin bad++; $display("FAIL err_no_more_xfer: got %0d/%0d want %0d/%0d", q_addr.size(), o_nsc, e_addr.size(), e_nsc); end
    sl_err[3] = 0;
    model(); run_script(0, 300);
    total++; if ({error, done} !== 2'b01) begin bad++; $display("FAIL err_rerun_flags: got %b want 01", {error, done}); end
    total++; if (q_addr.size() != 5 || err_idx !== '0) begin bad++; $display("FAIL err_rerun: got %0d txns idx %0d want 5 idx 0", q_addr.size(), err_idx); end
  endtask

  task automatic test_no_end();
    clear_script();
    for (int i = 0; i < N; i++) begin
      set_entry(i, (i == 5) ? RD : WR, i % 2, 32'h6200_0000 + 32'(i << 4), $urandom);
      sl_rdata[i] = s_data[i];
      sl_aw[i] = $urandom_range(0, 2);
    end
    model(); run_script(4, 400);
    total++; if (q_addr.size() != 8) begin bad++; $display("FAIL ne_ntxn: got %0d want 8", q_addr.size()); end
    total++; if (rom_addr !== 3'd7) begin bad++; $display("FAIL ne_rom_addr: got %0d want 7", rom_addr); end
    total++; if ({done, error, busy} !== 3'b100) begin bad++; $display("FAIL ne_flags: got %b want 100", {done, error, busy}); end
    total++; if (o_term != e_term) begin bad++; $display("FAIL ne_done_cycle: got %0d want %0d", o_term, e_term); end
    repeat (4) @(negedge clk_80m);
    total++; if (rom_addr !== 3'd7 || q_addr.size() != 8) begin bad++; $display("FAIL ne_no_wrap: got addr %0d txns %0d want 7/8", rom_addr, q_addr.size()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int k, r;
      clear_script();
      k = 0;
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 11);
        set_entry(i, (r < 4) ? WR : (r < 8) ? RD : (r < 10) ? WT : ((i > 2) ? END : WR),
                  ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6)), $urandom, $urandom);
        if (s_op[i] == WR || s_op[i] == RD) begin
          sl_aw[k] = $urandom_range(0, 2); sl_dw[k] = $urandom_range(0, 2);
          sl_rdata[k] = ($urandom_range(0, 1) == 0) ? s_data[i] : s_data[i] ^ (32'h1 << $urandom_range(0, 31));
          sl_err[k] = ($urandom_range(0, 9) == 0);
          k++;
        end
      end
      model(); run_script(0, 600);
      total++; if (o_term != e_term) begin bad++; $display("FAIL rnd%0d_cycle: got %0d want %0d", it, o_term, e_term); end
      total++; if ({done, error, busy} !== {e_done, e_error, 1'b0}) begin bad++; $display("FAIL rnd%0d_flags: got %b want %b", it, {done, error, busy}, {e_done, e_error, 1'b0}); end
      total++; if (err_idx !== IDX_W'(e_err_idx) || mismatch_cnt !== 8'(e_mm)) begin bad++; $display("FAIL rnd%0d_idx_mm: got %0d/%0d want %0d/%0d", it, err_idx, mismatch_cnt, e_err_idx, e_mm); end
      total++; if (rom_addr !== IDX_W'(e_last_idx) || o_nsc != e_nsc || o_unstable != 0) begin bad++; $display("FAIL rnd%0d_bus: got addr %0d nsc %0d unst %0d want %0d/%0d/0", it, rom_addr, o_nsc, o_unstable, e_last_idx, e_nsc); end
      total++; if (q_addr.size() != e_addr.size()) begin bad++; $display("FAIL rnd%0d_ntxn: got %0d want %0d", it, q_addr.size(), e_addr.size()); end
      else begin
        for (int j = 0; j < e_addr.size(); j++) begin
          total++;
          if (q_addr[j] !== e_addr[j] || q_write[j] !== e_write[j] || (e_write[j] && q_wdata[j] !== e_wdata[j])) begin
            bad++; $display("FAIL rnd%0d_txn%0d: got %h/%b/%h want %h/%b/%h", it, j, q_addr[j], q_write[j], q_wdata[j], e_addr[j], e_write[j], e_wdata[j]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_data();
    int n;
    clear_script();
    set_entry(0, RD, 0, 32'h60C0_0000, 32'h0000_00AA); sl_rdata[0] = 32'h0000_00AB;
    set_entry(1, WR, 0, 32'h6300_0000, 32'h0000_0099); sl_dw[1] = 4;
    @(posedge clk_80m); #1;
    sl_k = 0;
    @(negedge clk_80m); start = 1'b1;
    @(negedge clk_80m); start = 1'b0;
    n = 0;
    while (!(sl_phase == 3 && sl_k == 1) && n < 100) begin @(negedge clk_80m); #1; n++; end
    total++; if (n >= 100) begin bad++; $display("FAIL rst_reach_data: got timeout want data phase"); end
    total++; if (mismatch_cnt !== 8'd1 || busy !== 1'b1) begin bad++; $display("FAIL rst_pre_state: got mm %0d busy %b want 1/1", mismatch_cnt, busy); end
    por_rst_n = 1'b0;
    @(negedge clk_80m);
    total++; if (bus.proc_htrans !== 2'b00) begin bad++; $display("FAIL rst_htrans: got %b want 00", bus.proc_htrans); end
    total++; if ({busy, done, error, err_idx, mismatch_cnt, rom_addr} !== '0) begin bad++; $display("FAIL rst_flags: got %0h want 0", {busy, done, error, err_idx, mismatch_cnt, rom_addr}); end
    @(negedge clk_80m);
    por_rst_n = 1'b1;
    repeat (3) @(negedge clk_80m);
    total++; if (busy !== 1'b0 || bus.proc_htrans !== 2'b00) begin bad++; $display("FAIL rst_stays_idle: got busy %b htrans %b want 0/00", busy, bus.proc_htrans); end
  endtask

  initial begin
    clear_script();
    test_reset();
    test_single_write();
    test_delay();
    test_wait_states();
    test_read_mismatch();
    test_bus_error();
    test_no_end();
    test_random();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
